soc_sw_poller: RTL and testbench

Avalon-MM master that periodically reads the 8-bit switch PIO's data register (address 0) and debounces the sampled value. It publishes a stable switch word with a one-cycle change strobe and per-bit change mask. It sits between the switch PIO slave and fabric logic that needs clean switch events without a Nios II polling loop.

---
 rtl/soc_sw_poller_pkg.sv | 17 +
 rtl/soc_sw_debounce.sv | 58 +++++
 rtl/soc_sw_poller.sv | 106 ++++++++++
 tb/tb_soc_sw_poller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/soc_sw_poller_pkg.sv
// Shared types and constants for the switch PIO poller.
// Used by soc_sw_poller (optional IRQ via SOC_SW_POLLER_IRQ_EN) and soc_sw_debounce.
package soc_sw_poller_pkg;

  localparam int unsigned SW_WIDTH = 8;
  localparam int unsigned AVM_ADDR_W = 2;
  localparam int unsigned AVM_DATA_W = 32;

  localparam logic [AVM_ADDR_W-1:0] SW_PIO_DATA_ADDR = 2'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } poll_state_e;

endpackage

// File: rtl/soc_sw_debounce.sv
// Debounces strobed switch samples: a candidate must repeat STABLE_COUNT times before commit.
// Part of soc_sw_poller; commit_c feeds the optional IRQ (SOC_SW_POLLER_IRQ_EN).
module soc_sw_debounce
  import soc_sw_poller_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_en,
  input  logic [SW_WIDTH-1:0] sample,
  output logic [SW_WIDTH-1:0] sw_value,
  output logic [SW_WIDTH-1:0] sw_changed,
  output logic                sw_valid,
  output logic                commit_c
);

  localparam int unsigned CNT_W = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

  logic [SW_WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Candidate/saturating-count update for the current sample
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    if (sample_en) begin
      if (sample != cand_q) begin
        cand_d = sample;
        cnt_d  = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      commit_c = (cnt_d == CNT_MAX) && (cand_d != sw_value);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q     <= '0;
      cnt_q      <= '0;
      sw_value   <= '0;
      sw_changed <= '0;
      sw_valid   <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      sw_valid <= commit_c;
      if (commit_c) begin
        sw_changed <= sw_value ^ cand_d;
        sw_value   <= cand_d;
      end
    end
  end

endmodule

// File: rtl/soc_sw_poller.sv
// Avalon-MM master polling the switch PIO data register every POLL_DIV cycles, with debounce.
// Define SOC_SW_POLLER_IRQ_EN to add the sticky irq/irq_ack pair.
module soc_sw_poller
  import soc_sw_poller_pkg::*;
#(
  parameter int unsigned POLL_DIV     = 50000,
  parameter int unsigned STABLE_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [AVM_ADDR_W-1:0] avm_address,
  output logic                  avm_read,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  output logic [SW_WIDTH-1:0]   sw_value,
  output logic                  sw_valid,
  output logic [SW_WIDTH-1:0]   sw_changed
`ifdef SOC_SW_POLLER_IRQ_EN
  ,
  output logic                  irq,
  input  logic                  irq_ack
`endif
);

  localparam int unsigned DIV_W = $clog2(POLL_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick_c;
  poll_state_e      state_q, state_d;
  logic             read_d;
  logic             commit_c;
  logic             unused_readdata_hi;

  assign tick_c = (div_q == DIV_LAST);
  assign unused_readdata_hi = ^avm_readdata[AVM_DATA_W-1:SW_WIDTH];

  // Free-running sample-period divider
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (tick_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    read_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_c) begin
          state_d = READ;
          read_d  = 1'b1;
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= '0;
    end else begin
      state_q     <= state_d;
      avm_read    <= read_d;
      avm_address <= SW_PIO_DATA_ADDR;
    end
  end

  // Readdata is valid while in CAPTURE, one cycle after the read strobe
  soc_sw_debounce #(
    .STABLE_COUNT(STABLE_COUNT)
  ) u_debounce (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_en  (state_q == CAPTURE),
    .sample     (avm_readdata[SW_WIDTH-1:0]),
    .sw_value   (sw_value),
    .sw_changed (sw_changed),
    .sw_valid   (sw_valid),
    .commit_c   (commit_c)
  );

`ifdef SOC_SW_POLLER_IRQ_EN
  // Sticky interrupt; a new commit wins over a simultaneous acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (commit_c) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`else
  logic unused_commit;
  assign unused_commit = commit_c;
`endif

endmodule

// File: tb/tb_soc_sw_poller.sv
// Self-checking bench for soc_sw_poller with a history-window debounce model.
module tb_soc_sw_poller;

  localparam int unsigned P  = 8;
  localparam int unsigned SC = 3;
  localparam int NT = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = '0;
  logic [7:0]  sw_value;
  logic        sw_valid;
  logic [7:0]  sw_changed;
`ifdef SOC_SW_POLLER_IRQ_EN
  logic        irq;
  logic        irq_ack = 1'b0;
  logic        ack_q = 1'b0;
`endif

  always #5 clk = ~clk;

  soc_sw_poller #(
    .POLL_DIV(P),
    .STABLE_COUNT(SC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .avm_address  (avm_address),
    .avm_read     (avm_read),
    .avm_readdata (avm_readdata),
    .sw_value     (sw_value),
    .sw_valid     (sw_valid),
    .sw_changed   (sw_changed)
`ifdef SOC_SW_POLLER_IRQ_EN
    ,
    .irq          (irq),
    .irq_ack      (irq_ack)
`endif
  );

  logic [31:0] tbl [NT];
  int sidx = 0;
  int base = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Slave model: registered read data, one cycle after avm_read
  always @(posedge clk) begin
    if (avm_read) begin
      avm_readdata <= tbl[sidx];
      if (sidx < NT - 1) sidx <= sidx + 1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

`ifdef SOC_SW_POLLER_IRQ_EN
  always @(posedge clk) ack_q <= irq_ack;
`endif

  // Model: commit when the last SC samples agree and differ from the published word
  logic [7:0] hist [$];
  logic [7:0] exp_value = '0;
  logic [7:0] exp_changed = '0;
  logic [7:0] s;
  bit         exp_irq = 1'b0;
  bit         commit;
  bit         same;
  int         idx;

  always @(negedge clk) begin
    if (!reset_n) begin
      hist.delete();
      exp_value   = '0;
      exp_changed = '0;
      exp_irq     = 1'b0;
      base        = sidx;
      chk("rst_read", 32'(avm_read), 32'd0);
      chk("rst_addr", 32'(avm_address), 32'd0);
      chk("rst_value", 32'(sw_value), 32'd0);
      chk("rst_valid", 32'(sw_valid), 32'd0);
      chk("rst_changed", 32'(sw_changed), 32'd0);
`ifdef SOC_SW_POLLER_IRQ_EN
      chk("rst_irq", 32'(irq), 32'd0);
`endif
    end else begin
      commit = 1'b0;
      if (cyc >= int'(P) + 2 && (cyc - 2) % int'(P) == 0) begin
        idx = base + (cyc - 2) / int'(P) - 1;
        if (idx > NT - 1) idx = NT - 1;
        s = tbl[idx][7:0];
        hist.push_back(s);
        if (hist.size() >= int'(SC)) begin
          same = 1'b1;
          for (int i = 0; i < int'(SC); i++)
            if (hist[hist.size() - 1 - i] != s) same = 1'b0;
          if (same && s != exp_value) begin
            commit      = 1'b1;
            exp_changed = exp_value ^ s;
            exp_value   = s;
          end
        end
      end
`ifdef SOC_SW_POLLER_IRQ_EN
      if (commit)     exp_irq = 1'b1;
      else if (ack_q) exp_irq = 1'b0;
      chk("irq", 32'(irq), 32'(exp_irq));
`endif
      chk("avm_read", 32'(avm_read), 32'(cyc > 0 && cyc % int'(P) == 0));
      chk("avm_address", 32'(avm_address), 32'd0);
      chk("sw_value", 32'(sw_value), 32'(exp_value));
      chk("sw_changed", 32'(sw_changed), 32'(exp_changed));
      chk("sw_valid", 32'(sw_valid), 32'(commit));
    end
  end

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc != n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: timed out at cyc %0d waiting for %0d", cyc, n);
    end
  endtask

  initial begin
    for (int i = 0; i < NT; i++) tbl[i] = 32'h0000_005A;
    for (int i = 0; i < 3; i++)  tbl[i] = 32'h0000_00A5;
    tbl[3] = 32'h01; tbl[4] = 32'h00; tbl[5] = 32'h01; tbl[6] = 32'h01; tbl[7] = 32'h01;
    for (int i = 8; i < 11; i++)  tbl[i] = 32'h0000_0000;
    for (int i = 11; i < 14; i++) tbl[i] = 32'hFFFF_FF00;
    for (int i = 14; i < 27; i++) tbl[i] = 32'h0000_003C;

    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;

    wait_cyc(8);
    chk("lit_first_read", 32'(avm_read), 32'd1);
    wait_cyc(26);
    chk("lit_a5_valid", 32'(sw_valid), 32'd1);
    chk("lit_a5_value", 32'(sw_value), 32'hA5);
    chk("lit_a5_changed", 32'(sw_changed), 32'hA5);
`ifdef SOC_SW_POLLER_IRQ_EN
    chk("lit_irq_set", 32'(irq), 32'd1);
    wait_cyc(30);
    irq_ack = 1'b1;
    wait_cyc(31);
    irq_ack = 1'b0;
    wait_cyc(32);
    chk("lit_irq_clr", 32'(irq), 32'd0);
    wait_cyc(65);
    irq_ack = 1'b1;
`endif
    wait_cyc(66);
`ifdef SOC_SW_POLLER_IRQ_EN
    irq_ack = 1'b0;
    chk("lit_irq_set_wins", 32'(irq), 32'd1);
`endif
    chk("lit_bounce_valid", 32'(sw_valid), 32'd1);
    chk("lit_bounce_value", 32'(sw_value), 32'h01);
    chk("lit_bounce_changed", 32'(sw_changed), 32'hA4);
    wait_cyc(114);
    chk("lit_upper_value", 32'(sw_value), 32'h00);
    wait_cyc(216);
    chk("lit_hold_changed", 32'(sw_changed), 32'h3C);

    wait_cyc(224);
    chk("lit_mid_read", 32'(avm_read), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("lit_async_read", 32'(avm_read), 32'd0);
    chk("lit_async_value", 32'(sw_value), 32'd0);
    chk("lit_async_changed", 32'(sw_changed), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    wait_cyc(7);
    chk("lit_no_early_read", 32'(avm_read), 32'd0);
    wait_cyc(8);
    chk("lit_read_after_rst", 32'(avm_read), 32'd1);
    wait_cyc(26);
    chk("lit_5a_value", 32'(sw_value), 32'h5A);
    chk("lit_5a_changed", 32'(sw_changed), 32'h5A);
    wait_cyc(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
